// File: rtl/fixed_point_cpu.sv
// fixed_point_cpu: fixed-function engine that runs three built-in programs
// (16.8 divide, mean of 8.8 values, covariance of byte pairs) over an
// internal 256-byte data memory, one program per Start/Ack handshake.

// Data memory: byte array Core with one synchronous write port and one
// combinational read port. The environment may access Core hierarchically.
module fixed_point_cpu_dm #(
  parameter int DM_WORDS = 256
) (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);
  logic [7:0] Core [0:DM_WORDS-1];

  // Byte write port driven by the sequencer.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      Core[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = Core[raddr_i];
endmodule

module fixed_point_cpu #(
  parameter int DM_WORDS = 256
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic [3:0] {
    S_P1_HI = 4'd0, S_P1_LO = 4'd1, S_P1_D = 4'd2, S_N = 4'd3,
    S_P2_HI = 4'd4, S_P2_LO = 4'd5, S_P3_S = 4'd6, S_P3_CX = 4'd7,
    S_P3_CY = 4'd8, S_DIV = 4'd9, S_POST = 4'd10, S_WR = 4'd11, S_FIN = 4'd12
  } step_e;
  localparam logic [1:0] PRG_P1 = 2'd0;
  localparam logic [1:0] PRG_P2 = 2'd1;
  localparam logic [1:0] PRG_P3 = 2'd2;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [1:0]  prog_q, prog_d;
  step_e       step_q, step_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  n_q, n_d, i_q, i_d, tmp_q, tmp_d, dvs_q, dvs_d;
  logic [7:0]  rem_q, rem_d, wptr_q, wptr_d;
  logic [15:0] acc_q, acc_d, xbar_q, xbar_d, ybar_q, ybar_d;
  logic [23:0] quo_q, quo_d, res_q, res_d;
  logic        neg_q;
  logic [4:0]  dcnt_q, dcnt_d;
  logic [1:0]  wcnt_q, wcnt_d;

  logic        run_s, div_go_s, we_s, fit_s;
  logic [23:0] div_num_s, quot_s, dx_s, dy_s, prod_s;
  logic [7:0]  raddr_s, rdata_s;
  logic [8:0]  trial_s, diff_s;
  logic [15:0] t_s;

  // Magnitude of a 24-bit two's-complement value (unsigned result).
  function automatic logic [23:0] mag24(input logic [23:0] v);
    return v[23] ? (~v + 24'd1) : v;
  endfunction

  fixed_point_cpu_dm #(.DM_WORDS(DM_WORDS)) DM1 (
    .clk_i(Clk), .we_i(we_s), .waddr_i(wptr_q), .wdata_i(res_q[23:16]),
    .raddr_i(raddr_s), .rdata_o(rdata_s)
  );

  // A Start seen while running aborts the step so nothing is written.
  assign run_s   = (state_q == RUN) && !Start;
  // Restoring divider step: shift in next dividend bit, subtract if it fits.
  assign trial_s = {rem_q, quo_q[23]};
  assign diff_s  = trial_s - {1'b0, dvs_q};
  assign fit_s   = (trial_s >= {1'b0, dvs_q});
  // Signed quotient; a zero divisor yields all ones.
  assign quot_s  = (dvs_q == 8'd0) ? 24'hFFFFFF : (neg_q ? (~quo_q + 24'd1) : quo_q);
  // Covariance term: only product bits [23:8] are needed, so 24-bit wrap suffices.
  assign dx_s    = {8'd0, tmp_q, 8'd0} - {8'd0, xbar_q};
  assign dy_s    = {8'd0, rdata_s, 8'd0} - {8'd0, ybar_q};
  assign prod_s  = dx_s * dy_s;
  assign t_s     = 16'(prod_s >> 8);
  assign Ack     = ack_q;

  // Handshake state, Ack and program selector registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      prog_q  <= PRG_P1;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      prog_q  <= prog_d;
    end
  end

  // Handshake next state: Start wins over everything, including completion.
  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   state_d = RUN;
        RUN:     state_d = (step_q == S_FIN) ? DONE : RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs: Ack mirrors DONE; the selector advances as Ack rises.
  always_comb begin
    ack_d  = (state_d == DONE);
    prog_d = prog_q;
    if ((state_q == RUN) && (state_d == DONE)) begin
      prog_d = (prog_q == PRG_P3) ? PRG_P1 : (prog_q + 2'd1);
    end else begin
      prog_d = prog_q;
    end
  end

  // Program sequencer: next datapath values, read address and write strobe.
  always_comb begin
    step_d = step_q;  phase_d = phase_q; n_d = n_q;   i_d = i_q;
    tmp_d = tmp_q;    dvs_d = dvs_q;     rem_d = rem_q; wptr_d = wptr_q;
    acc_d = acc_q;    xbar_d = xbar_q;   ybar_d = ybar_q; quo_d = quo_q;
    res_d = res_q;    dcnt_d = dcnt_q;   wcnt_d = wcnt_q;
    raddr_s = 8'd0;   we_s = 1'b0;       div_go_s = 1'b0; div_num_s = 24'd0;
    if ((state_q == ARMED) && !Start) begin
      step_d = (prog_q == PRG_P1) ? S_P1_HI : S_N;
    end else if (run_s) begin
      case (step_q)
        S_P1_HI: begin raddr_s = 8'd0; acc_d = {rdata_s, acc_q[7:0]}; step_d = S_P1_LO; end
        S_P1_LO: begin raddr_s = 8'd1; acc_d = {acc_q[15:8], rdata_s}; step_d = S_P1_D; end
        S_P1_D: begin
          raddr_s = 8'd2; dvs_d = rdata_s;
          div_go_s = 1'b1; div_num_s = {acc_q, 8'd0}; step_d = S_DIV;
        end
        S_N: begin
          raddr_s = 8'd0; n_d = rdata_s; acc_d = 16'd0; i_d = 8'd0; phase_d = 2'd0;
          step_d = (prog_q == PRG_P2) ? S_P2_HI : S_P3_S;
        end
        S_P2_HI: begin
          if (i_q == n_q) begin
            dvs_d = n_q; div_go_s = 1'b1; div_num_s = {{8{acc_q[15]}}, acc_q}; step_d = S_DIV;
          end else begin
            raddr_s = {i_q[6:0], 1'b1}; tmp_d = rdata_s; step_d = S_P2_LO;
          end
        end
        S_P2_LO: begin
          raddr_s = {i_q[6:0], 1'b0} + 8'd2;
          acc_d = acc_q + {tmp_q, rdata_s}; i_d = i_q + 8'd1; step_d = S_P2_HI;
        end
        S_P3_S: begin
          if (i_q == n_q) begin
            dvs_d = n_q; div_go_s = 1'b1; div_num_s = {{8{acc_q[15]}}, acc_q}; step_d = S_DIV;
          end else begin
            raddr_s = (phase_q == 2'd0) ? (i_q + 8'd1) : (n_q + i_q + 8'd1);
            acc_d = acc_q + {rdata_s, 8'd0}; i_d = i_q + 8'd1;
          end
        end
        S_P3_CX: begin
          if (i_q == n_q) begin
            dvs_d = n_q; div_go_s = 1'b1; div_num_s = {{8{acc_q[15]}}, acc_q}; step_d = S_DIV;
          end else begin
            raddr_s = i_q + 8'd1; tmp_d = rdata_s; step_d = S_P3_CY;
          end
        end
        S_P3_CY: begin
          raddr_s = n_q + i_q + 8'd1;
          acc_d = acc_q + t_s; i_d = i_q + 8'd1; step_d = S_P3_CX;
        end
        S_DIV: begin
          if (dcnt_q == 5'd0) begin
            step_d = S_POST;
          end else begin
            rem_d  = fit_s ? 8'(diff_s) : 8'(trial_s);
            quo_d  = {quo_q[22:0], fit_s};
            dcnt_d = dcnt_q - 5'd1;
          end
        end
        S_POST: begin
          if (prog_q == PRG_P1) begin
            res_d = quot_s; wcnt_d = 2'd3; wptr_d = 8'd4; step_d = S_WR;
          end else if ((prog_q == PRG_P3) && (phase_q == 2'd0)) begin
            xbar_d = quot_s[15:0]; acc_d = 16'd0; i_d = 8'd0; phase_d = 2'd1; step_d = S_P3_S;
          end else if ((prog_q == PRG_P3) && (phase_q == 2'd1)) begin
            ybar_d = quot_s[15:0]; acc_d = 16'd0; i_d = 8'd0; phase_d = 2'd2; step_d = S_P3_CX;
          end else begin
            res_d = {quot_s[15:0], 8'd0}; wcnt_d = 2'd2; wptr_d = {n_q[6:0], 1'b1}; step_d = S_WR;
          end
        end
        S_WR: begin
          if (wcnt_q == 2'd0) begin
            step_d = S_FIN;
          end else begin
            we_s = 1'b1; res_d = {res_q[15:0], 8'd0};
            wptr_d = wptr_q + 8'd1; wcnt_d = wcnt_q - 2'd1;
          end
        end
        S_FIN:   step_d = S_FIN;
        default: step_d = S_FIN;
      endcase
    end else begin
      step_d = step_q;
    end
  end

  // Datapath registers; a divide launch preloads the serial divider.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      step_q <= S_P1_HI; phase_q <= 2'd0; n_q <= 8'd0;  i_q <= 8'd0;
      tmp_q <= 8'd0;     dvs_q <= 8'd0;   rem_q <= 8'd0; wptr_q <= 8'd0;
      acc_q <= 16'd0;    xbar_q <= 16'd0; ybar_q <= 16'd0; quo_q <= 24'd0;
      res_q <= 24'd0;    neg_q <= 1'b0;   dcnt_q <= 5'd0; wcnt_q <= 2'd0;
    end else begin
      step_q <= step_d; phase_q <= phase_d; n_q <= n_d;   i_q <= i_d;
      tmp_q <= tmp_d;   dvs_q <= dvs_d;     wptr_q <= wptr_d;
      acc_q <= acc_d;   xbar_q <= xbar_d;   ybar_q <= ybar_d;
      res_q <= res_d;   wcnt_q <= wcnt_d;
      if (div_go_s) begin
        quo_q <= mag24(div_num_s); neg_q <= div_num_s[23];
        rem_q <= 8'd0;             dcnt_q <= 5'd24;
      end else begin
        quo_q <= quo_d; neg_q <= neg_q; rem_q <= rem_d; dcnt_q <= dcnt_d;
      end
    end
  end
endmodule

// File: tb/tb_fixed_point_cpu.sv
// Scoreboard bench for fixed_point_cpu: the stimulus process computes each
// program's expected memory image from plain arithmetic and queues it; the
// monitor compares DUT memory whenever Ack rises.
module tb_fixed_point_cpu;
  logic Clk, Reset, Start, Ack;
  int   errors = 0;
  int   checks = 0;
  int   prog_m = 0;
  logic ack_prev = 1'b0;
  logic [7:0] mem_m [0:255];

  typedef struct {
    logic [2047:0] img;
    int            prog;
    int            n;
  } exp_t;
  exp_t sb[$];

  fixed_point_cpu #(.DM_WORDS(256)) dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic longint lo16(input longint v);
    longint w;
    w = v % 65536;
    if (w < 0) w += 65536;
    return w;
  endfunction

  function automatic longint sx16(input longint v);
    longint w;
    w = lo16(v);
    return (w >= 32768) ? (w - 65536) : w;
  endfunction

  // Truncating signed divide; a zero divisor gives all ones.
  function automatic longint div_ref(input longint num, input longint d);
    if (d == 0) return -1;
    return num / d;
  endfunction

  // Expected memory image after running program prog on mem_m.
  function automatic exp_t model_run(input int prog);
    exp_t e;
    longint r, n, s, sx, sy, xb, yb, ts, p;
    logic [63:0] rv, pv;
    int a0;
    for (int k = 0; k < 256; k++) e.img[8*k +: 8] = mem_m[k];
    e.prog = prog;
    e.n = 0;
    if (prog == 0) begin
      r  = div_ref(sx16(256 * int'(mem_m[0]) + int'(mem_m[1])) * 256, int'(mem_m[2]));
      rv = r;
      e.img[8*4 +: 8] = rv[23:16];
      e.img[8*5 +: 8] = rv[15:8];
      e.img[8*6 +: 8] = rv[7:0];
    end else begin
      n = int'(mem_m[0]);
      e.n = int'(n);
      if (prog == 1) begin
        s = 0;
        for (int i = 0; i < n; i++) s += 256 * int'(mem_m[2*i+1]) + int'(mem_m[2*i+2]);
        r = div_ref(sx16(s), n);
      end else begin
        sx = 0; sy = 0; ts = 0;
        for (int i = 1; i <= n; i++) begin
          sx += 256 * int'(mem_m[i]);
          sy += 256 * int'(mem_m[n+i]);
        end
        xb = lo16(div_ref(sx16(sx), n));
        yb = lo16(div_ref(sx16(sy), n));
        for (int i = 1; i <= n; i++) begin
          p  = (256 * longint'(mem_m[i]) - xb) * (256 * longint'(mem_m[n+i]) - yb);
          pv = p;
          ts += longint'(pv[23:8]);
        end
        r = div_ref(sx16(ts), n);
      end
      rv = r;
      a0 = int'((2 * n + 1) % 256);
      e.img[8*a0 +: 8] = rv[15:8];
      a0 = int'((2 * n + 2) % 256);
      e.img[8*a0 +: 8] = rv[7:0];
    end
    return e;
  endfunction

  // Monitor: on each Ack rise, pop the oldest expectation and compare memory.
  always @(negedge Clk) begin : monitor
    exp_t e;
    int mism;
    int a;
    if (Reset && Ack && !ack_prev) begin
      check("scoreboard_has_entry", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.prog == 0) begin
          for (int k = 4; k < 7; k++)
            check($sformatf("p1_core%0d", k), 64'(dut.DM1.Core[k]), 64'(e.img[8*k +: 8]));
        end else begin
          for (int k = 1; k < 3; k++) begin
            a = (2 * e.n + k) % 256;
            check($sformatf("p%0d_n%0d_core%0d", e.prog + 1, e.n, a),
                  64'(dut.DM1.Core[a]), 64'(e.img[8*a +: 8]));
          end
        end
        mism = 0;
        for (int k = 0; k < 256; k++)
          if (dut.DM1.Core[k] !== e.img[8*k +: 8]) mism++;
        check($sformatf("p%0d_image_bytes_differing", e.prog + 1), 64'(mism), 64'd0);
      end
    end
    ack_prev = Ack;
  end

  task automatic load_dut();
    for (int k = 0; k < 256; k++) dut.DM1.Core[k] = mem_m[k];
  endtask

  // Queue the expectation, pulse Start for two cycles, wait bounded for Ack.
  task automatic run_prog(input string tag);
    exp_t e;
    int bound;
    logic got;
    e = model_run(prog_m);
    sb.push_back(e);
    load_dut();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); check({tag, "_ack_low_during_start"}, 64'(Ack), 64'd0);
    @(negedge Clk); Start = 1'b0;
    bound = (e.prog == 0) ? 100 : 8 * e.n + 150;
    got = 1'b0;
    for (int cyc = 0; cyc < bound && !got; cyc++) begin
      @(negedge Clk);
      if (Ack) got = 1'b1;
    end
    check({tag, "_ack_within_latency"}, 64'(got), 64'd1);
    for (int k = 0; k < 256; k++) mem_m[k] = e.img[8*k +: 8];
    prog_m = (prog_m + 1) % 3;
    @(negedge Clk);
    check({tag, "_ack_held"}, 64'(Ack), 64'(got));
  endtask

  initial begin
    int n;
    Reset = 1'b0;
    Start = 1'b0;
    for (int k = 0; k < 256; k++) mem_m[k] = 8'($urandom_range(0, 255));
    load_dut();
    repeat (3) @(negedge Clk);
    check("reset_ack", 64'(Ack), 64'd0);
    Reset = 1'b1;
    @(negedge Clk);
    check("idle_ack", 64'(Ack), 64'd0);

    // P1: 50.0 / 25 = 2.0
    mem_m[0] = 8'h32; mem_m[1] = 8'h00; mem_m[2] = 8'h19;
    run_prog("t1");
    check("t1_result", 64'({dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6]}), 64'h020000);

    // P2: mean of 1..9 = 5.0
    mem_m[0] = 8'd9;
    for (int i = 0; i < 9; i++) begin
      mem_m[2*i+1] = 8'(i + 1);
      mem_m[2*i+2] = 8'h00;
    end
    run_prog("t2");
    check("t2_result", 64'({dut.DM1.Core[19], dut.DM1.Core[20]}), 64'h0500);

    // P3: covariance example
    mem_m[0] = 8'd3;  mem_m[1] = 8'd1;  mem_m[2] = 8'd2; mem_m[3] = 8'd3;
    mem_m[4] = 8'd10; mem_m[5] = 8'd20; mem_m[6] = 8'd27;
    run_prog("t3");
    check("t3_result", 64'({dut.DM1.Core[7], dut.DM1.Core[8]}), 64'h05AA);

    // Selector wraps to P1: negative divide
    mem_m[0] = 8'hFF; mem_m[1] = 8'h00; mem_m[2] = 8'h03;
    run_prog("t4_wrap");
    check("t4_result", 64'({dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6]}), 64'hFFAAAB);

    // Abort P2 mid-run with Reset; nothing may be written
    mem_m[0] = 8'd20;
    load_dut();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); @(negedge Clk); Start = 1'b0;
    repeat (10) @(negedge Clk);
    Reset = 1'b0;
    #1 check("abort_ack_low", 64'(Ack), 64'd0);
    @(negedge Clk); Reset = 1'b1;
    prog_m = 0;

    // Next Start must run P1; divide by zero
    mem_m[0] = 8'h12; mem_m[1] = 8'h34; mem_m[2] = 8'h00;
    run_prog("t5_p1_div0");
    check("t5_result", 64'({dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6]}), 64'hFFFFFF);

    // Asynchronous reset while Ack is high
    #2 Reset = 1'b0;
    #1 check("async_reset_clears_ack", 64'(Ack), 64'd0);
    @(negedge Clk); Reset = 1'b1;
    prog_m = 0;

    // Randomised runs cycling through all programs, including N=0 and N=126
    for (int j = 0; j < 12; j++) begin
      for (int k = 0; k < 256; k++) mem_m[k] = 8'($urandom_range(0, 255));
      n = (j < 3) ? 0 : ((j < 6) ? 126 : int'($urandom_range(1, 126)));
      if (prog_m != 0) begin
        mem_m[0] = 8'(n);
      end else if (j == 3) begin
        mem_m[0] = 8'h80; mem_m[1] = 8'h00; mem_m[2] = 8'h01;
      end
      run_prog($sformatf("rand%0d", j));
    end

    repeat (3) @(negedge Clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
